// File: rtl/chronos_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chronos_pkg
//  Description : Shared definitions for the pipeline hazard controller:
//                datapath widths, hazard FSM state encoding, the bundled
//                pipeline-control word and the load-use detection helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package chronos_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // ------------------------------------------------------------------
    // Hazard FSM state encoding
    // ------------------------------------------------------------------
    typedef logic [1:0] state_t;

    localparam state_t c_st_run       = 2'd0;  // normal flow
    localparam state_t c_st_lu_bubble = 2'd1;  // ID/EX holds the load-use bubble
    localparam state_t c_st_freeze    = 2'd2;  // data memory busy last cycle

    // ------------------------------------------------------------------
    // Pipeline control word, one field per controller output strobe
    // ------------------------------------------------------------------
    typedef struct packed {
        logic fetch_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_flush;
        logic idex_flush;
        logic redirect_valid;
    } hz_ctrl_t;

    // Reset: stages held, both front-end registers loaded with bubbles.
    localparam hz_ctrl_t c_ctrl_reset    = hz_ctrl_t'(6'b000_110);
    // Memory busy: everything frozen, nothing flushed.
    localparam hz_ctrl_t c_ctrl_freeze   = hz_ctrl_t'(6'b000_000);
    // Mispredict: advance, squash the two younger instructions, redirect.
    localparam hz_ctrl_t c_ctrl_redirect = hz_ctrl_t'(6'b111_111);
    // Load-use: hold PC/IF-ID, insert a bubble into ID/EX, let the load go.
    localparam hz_ctrl_t c_ctrl_lu_stall = hz_ctrl_t'(6'b011_010);
    // Normal flow.
    localparam hz_ctrl_t c_ctrl_run      = hz_ctrl_t'(6'b111_000);

    // ------------------------------------------------------------------
    // Load-use hazard: a load in EX writes a non-zero register that the
    // instruction in IF/ID reads. Unused source fields arrive as x0, so
    // the rd != 0 test also filters them out.
    // ------------------------------------------------------------------
    function automatic logic load_use_hit(
        input logic                  mem_read,
        input logic                  reg_write,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2
    );
        return mem_read && reg_write && (rd != '0) &&
               ((rd == rs1) || (rd == rs2));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_perf_cnt
//  Description : Free-running event counter with synchronous clear. Wraps
//                from 2^XLEN-1 back to 0.
//  Ports       : clk   - clock
//                rst   - synchronous clear, active-high (wins over inc)
//                inc   - count one event this cycle
//                count - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_perf_cnt #(
    parameter int XLEN = chronos_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    output logic [XLEN-1:0] count
);

    localparam logic [XLEN-1:0] c_one = {{(XLEN-1){1'b0}}, 1'b1};

    logic [XLEN-1:0] r_count;

    // Natural modulo-2^XLEN arithmetic provides the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + c_one;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller. Arbitrates data-memory freeze,
//                branch mispredict redirect and load-use stall, producing
//                same-cycle (Mealy) enables/flushes for the pipeline
//                registers, plus stall and redirect performance counters.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                ifid_rs1/rs2        - source regs of instruction in IF/ID
//                idex_mem_read/rd/reg_write - load info of instruction in EX
//                ex_is_branch/prediction/taken/target/pc4 - branch in EX
//                dmem_busy           - data memory not ready
//                fetch_en/idex_en/exmem_en  - pipeline register enables
//                ifid_flush/idex_flush      - bubble insertion strobes
//                redirect_valid/redirect_pc - PC redirect
//                stall_count/flush_count    - performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int XLEN = chronos_pkg::XLEN
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [chronos_pkg::REG_ADDR_W-1:0] ifid_rs1,
    input  logic [chronos_pkg::REG_ADDR_W-1:0] ifid_rs2,
    input  logic                              idex_mem_read,
    input  logic [chronos_pkg::REG_ADDR_W-1:0] idex_rd,
    input  logic                              idex_reg_write,
    input  logic                              ex_is_branch,
    input  logic                              ex_prediction,
    input  logic                              ex_taken,
    input  logic [XLEN-1:0]                   ex_target,
    input  logic [XLEN-1:0]                   ex_pc4,
    input  logic                              dmem_busy,
    output logic                              fetch_en,
    output logic                              idex_en,
    output logic                              exmem_en,
    output logic                              ifid_flush,
    output logic                              idex_flush,
    output logic                              redirect_valid,
    output logic [XLEN-1:0]                   redirect_pc,
    output logic [XLEN-1:0]                   stall_count,
    output logic [XLEN-1:0]                   flush_count
);

    import chronos_pkg::*;

    state_t          r_state;
    state_t          w_next_state;
    hz_ctrl_t        w_ctrl;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_mispredict;
    logic            w_load_use;
    logic            w_lu_stall;
    logic            w_stall_inc;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_mispredict = ex_is_branch && (ex_taken != ex_prediction);
    assign w_load_use   = load_use_hit(idex_mem_read, idex_reg_write,
                                       idex_rd, ifid_rs1, ifid_rs2);

    // In LU_BUBBLE the load has moved on and ID/EX holds the bubble, but
    // the ID/EX inputs can still show the same match for this one cycle;
    // masking it bounds the load-use stall to a single cycle.
    assign w_lu_stall = w_load_use && (r_state != c_st_lu_bubble);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic (reset handled in the state register)
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = c_st_run;
        if (dmem_busy) begin
            w_next_state = c_st_freeze;
        end else if (w_mispredict) begin
            w_next_state = c_st_run;
        end else if (w_lu_stall) begin
            w_next_state = c_st_lu_bubble;
        end
    end

    // ------------------------------------------------------------------
    // Output logic (Mealy). A mispredict seen during a freeze stays on the
    // frozen ID/EX inputs, so it is issued in the first non-busy cycle and
    // then squashed by its own idex_flush -- no extra pending state needed.
    // ------------------------------------------------------------------
    always_comb begin
        w_ctrl        = c_ctrl_run;
        w_redirect_pc = '0;
        if (rst) begin
            w_ctrl = c_ctrl_reset;
        end else if (dmem_busy) begin
            w_ctrl = c_ctrl_freeze;
        end else if (w_mispredict) begin
            w_ctrl        = c_ctrl_redirect;
            w_redirect_pc = ex_taken ? ex_target : ex_pc4;
        end else if (w_lu_stall) begin
            w_ctrl = c_ctrl_lu_stall;
        end
    end

    assign fetch_en       = w_ctrl.fetch_en;
    assign idex_en        = w_ctrl.idex_en;
    assign exmem_en       = w_ctrl.exmem_en;
    assign ifid_flush     = w_ctrl.ifid_flush;
    assign idex_flush     = w_ctrl.idex_flush;
    assign redirect_valid = w_ctrl.redirect_valid;
    assign redirect_pc    = w_redirect_pc;

    // ------------------------------------------------------------------
    // Performance counters. fetch_en is also low during reset, which must
    // not be counted, hence the explicit rst qualifier.
    // ------------------------------------------------------------------
    assign w_stall_inc = !rst && !w_ctrl.fetch_en;

    hazard_perf_cnt #(
        .XLEN  (XLEN)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (stall_count)
    );

    hazard_perf_cnt #(
        .XLEN  (XLEN)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_ctrl.redirect_valid),
        .count (flush_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl: a directed vector
//                table, a hand-written long-freeze sequence and randomized
//                cycles compared against a rule-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    // Control word bit order: {fetch_en, idex_en, exmem_en, ifid_flush,
    // idex_flush, redirect_valid}
    localparam logic [5:0] E_RUN = 6'b111000;
    localparam logic [5:0] E_LU  = 6'b011010;
    localparam logic [5:0] E_FRZ = 6'b000000;
    localparam logic [5:0] E_RED = 6'b111111;
    localparam logic [5:0] E_RST = 6'b000110;

    typedef struct {
        logic        rst;
        logic        busy;
        logic        mr;
        logic        rw;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        br;
        logic        pred;
        logic        tkn;
        logic [31:0] tgt;
        logic [31:0] pc4;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [5:0]  eb;
        logic [31:0] epc;
        logic [31:0] es;
        logic [31:0] ef;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ifid_rs1, ifid_rs2, idex_rd;
    logic        idex_mem_read, idex_reg_write;
    logic        ex_is_branch, ex_prediction, ex_taken;
    logic [31:0] ex_target, ex_pc4;
    logic        dmem_busy;
    logic        fetch_en, idex_en, exmem_en, ifid_flush, idex_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc, stall_count, flush_count;

    int checks   = 0;
    int failures = 0;
    int obs_redirects = 0;

    // Reference model state: was the previous cycle a load-use stall?
    bit          m_masked = 1'b0;
    logic [31:0] m_stall  = '0;
    logic [31:0] m_flush  = '0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifid_rs1       (ifid_rs1),
        .ifid_rs2       (ifid_rs2),
        .idex_mem_read  (idex_mem_read),
        .idex_rd        (idex_rd),
        .idex_reg_write (idex_reg_write),
        .ex_is_branch   (ex_is_branch),
        .ex_prediction  (ex_prediction),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pc4         (ex_pc4),
        .dmem_busy      (dmem_busy),
        .fetch_en       (fetch_en),
        .idex_en        (idex_en),
        .exmem_en       (exmem_en),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    function automatic stim_t mk(input logic r, input logic b, input logic mr,
                                 input logic rw, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic br, input logic pred, input logic tkn,
                                 input logic [31:0] tgt, input logic [31:0] pc4);
        stim_t s;
        s.rst = r;   s.busy = b;  s.mr = mr;   s.rw = rw;
        s.rd  = rd;  s.rs1 = rs1; s.rs2 = rs2;
        s.br  = br;  s.pred = pred; s.tkn = tkn;
        s.tgt = tgt; s.pc4 = pc4;
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic [5:0] eb,
                                 input logic [31:0] epc, input logic [31:0] es,
                                 input logic [31:0] ef);
        vec_t v;
        v.s = s; v.eb = eb; v.epc = epc; v.es = es; v.ef = ef;
        return v;
    endfunction

    // Rule-level model: priority reset > busy > mispredict > load-use,
    // with a load-use ignored right after a load-use stall.
    task automatic model_step(input stim_t s, output logic [5:0] eb,
                              output logic [31:0] epc, output logic [31:0] es,
                              output logic [31:0] ef);
        bit mis, lu;
        mis = s.br && (s.tkn != s.pred);
        lu  = s.mr && s.rw && (s.rd != 0) && ((s.rd == s.rs1) || (s.rd == s.rs2));
        epc = 32'h0;
        if (s.rst) begin
            eb = E_RST;
        end else if (s.busy) begin
            eb = E_FRZ;
        end else if (mis) begin
            eb  = E_RED;
            epc = s.tkn ? s.tgt : s.pc4;
        end else if (lu && !m_masked) begin
            eb = E_LU;
        end else begin
            eb = E_RUN;
        end
        if (s.rst) begin
            m_stall  = 0;
            m_flush  = 0;
            m_masked = 1'b0;
        end else begin
            if (!eb[5]) m_stall = m_stall + 1;
            if (eb[0])  m_flush = m_flush + 1;
            m_masked = (eb == E_LU);
        end
        es = m_stall;
        ef = m_flush;
    endtask

    // Called at posedge+1: drive, check outputs at the negedge, then check
    // counters one time unit after the following posedge.
    task automatic run_cycle(input stim_t s, input logic [5:0] eb,
                             input logic [31:0] epc, input logic [31:0] es,
                             input logic [31:0] ef, input string tag);
        logic [5:0] got;
        rst = s.rst; dmem_busy = s.busy;
        idex_mem_read = s.mr; idex_reg_write = s.rw; idex_rd = s.rd;
        ifid_rs1 = s.rs1; ifid_rs2 = s.rs2;
        ex_is_branch = s.br; ex_prediction = s.pred; ex_taken = s.tkn;
        ex_target = s.tgt; ex_pc4 = s.pc4;
        #4;
        got = {fetch_en, idex_en, exmem_en, ifid_flush, idex_flush, redirect_valid};
        if (redirect_valid === 1'b1) obs_redirects++;
        checks++;
        if (got !== eb) begin
            failures++;
            $display("FAIL %s ctrl: got %b expected %b", tag, got, eb);
        end
        if (eb[0] || s.rst) begin
            checks++;
            if (redirect_pc !== epc) begin
                failures++;
                $display("FAIL %s redirect_pc: got %h expected %h", tag, redirect_pc, epc);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (stall_count !== es) begin
            failures++;
            $display("FAIL %s stall_count: got %0d expected %0d", tag, stall_count, es);
        end
        checks++;
        if (flush_count !== ef) begin
            failures++;
            $display("FAIL %s flush_count: got %0d expected %0d", tag, flush_count, ef);
        end
    endtask

    task automatic model_cycle(input stim_t s, input string tag);
        logic [5:0]  eb;
        logic [31:0] epc, es, ef;
        model_step(s, eb, epc, es, ef);
        run_cycle(s, eb, epc, es, ef, tag);
    endtask

    initial begin
        stim_t idle, s, lu7, mis104;
        int red_before;

        idle   = mk(0,0, 0,0,0,0,0, 0,0,0, 32'h0, 32'h0);
        lu7    = mk(0,0, 1,1,7,7,0, 0,0,0, 32'h0, 32'h0);
        mis104 = mk(0,0, 0,0,0,0,0, 1,1,0, 32'h40, 32'h104);

        // -------- directed table (sequential, hand-computed) --------
        tbl.push_back(mkv(mk(1,0, 0,0,0,0,0, 0,0,0, 0,0), E_RST, 32'h0, 0, 0));
        tbl.push_back(mkv(idle, E_RUN, 0, 0, 0));
        tbl.push_back(mkv(mk(0,0, 1,1,5,0,5, 0,0,0, 0,0), E_LU,  0, 1, 0));  // lw x5, rs2=x5
        tbl.push_back(mkv(mk(0,0, 1,1,5,0,5, 0,0,0, 0,0), E_RUN, 0, 1, 0));  // masked in bubble
        tbl.push_back(mkv(idle, E_RUN, 0, 1, 0));
        tbl.push_back(mkv(mk(0,0, 1,1,0,0,0, 0,0,0, 0,0), E_RUN, 0, 1, 0));  // rd=x0
        tbl.push_back(mkv(mk(0,0, 1,0,5,5,0, 0,0,0, 0,0), E_RUN, 0, 1, 0));  // no reg_write
        tbl.push_back(mkv(mk(0,0, 0,1,5,5,0, 0,0,0, 0,0), E_RUN, 0, 1, 0));  // not a load
        tbl.push_back(mkv(mk(0,0, 0,0,0,0,0, 1,0,1, 32'h40,32'h8), E_RED, 32'h40, 1, 1));
        tbl.push_back(mkv(mk(0,0, 0,0,0,0,0, 1,1,1, 32'h40,32'h8), E_RUN, 0, 1, 1));
        for (int i = 0; i < 3; i++) begin
            s = mis104; s.busy = 1'b1;
            tbl.push_back(mkv(s, E_FRZ, 0, 32'(2 + i), 1));
        end
        tbl.push_back(mkv(mis104, E_RED, 32'h104, 4, 2));
        tbl.push_back(mkv(mk(0,0, 1,1,7,7,0, 1,0,1, 32'h80,32'h10), E_RED, 32'h80, 4, 3));
        tbl.push_back(mkv(lu7, E_LU, 0, 5, 3));
        s = lu7; s.busy = 1'b1;
        tbl.push_back(mkv(s, E_FRZ, 0, 6, 3));                                // bubble -> freeze
        tbl.push_back(mkv(lu7, E_LU, 0, 7, 3));                               // not masked after freeze
        s = lu7; s.rst = 1'b1;
        tbl.push_back(mkv(s, E_RST, 0, 0, 0));                                // reset in LU_BUBBLE
        tbl.push_back(mkv(lu7, E_LU, 0, 1, 0));
        tbl.push_back(mkv(mk(0,1, 0,0,0,0,0, 0,0,0, 0,0), E_FRZ, 0, 2, 0));
        tbl.push_back(mkv(mk(1,1, 0,0,0,0,0, 1,0,1, 32'h44,0), E_RST, 0, 0, 0)); // reset in FREEZE
        tbl.push_back(mkv(lu7, E_LU, 0, 1, 0));
        tbl.push_back(mkv(mk(0,0, 0,0,0,0,0, 1,1,0, 32'h40,32'h200), E_RED, 32'h200, 1, 1));
        tbl.push_back(mkv(mk(0,0, 0,0,0,0,0, 0,1,0, 32'h40,32'h200), E_RUN, 0, 1, 1));
        tbl.push_back(mkv(mk(0,0, 1,1,3,3,9, 0,0,0, 0,0), E_LU, 0, 2, 1));

        rst = 1'b1; dmem_busy = 1'b0;
        idex_mem_read = 1'b0; idex_reg_write = 1'b0; idex_rd = '0;
        ifid_rs1 = '0; ifid_rs2 = '0;
        ex_is_branch = 1'b0; ex_prediction = 1'b0; ex_taken = 1'b0;
        ex_target = '0; ex_pc4 = '0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            run_cycle(tbl[i].s, tbl[i].eb, tbl[i].epc, tbl[i].es, tbl[i].ef,
                      $sformatf("vec%0d", i));
        end

        // -------- hand sequence: long freeze over a pending mispredict --------
        s = idle; s.rst = 1'b1;
        model_cycle(s, "seq_rst");
        red_before = obs_redirects;
        for (int i = 0; i < 5; i++) begin
            s = mis104; s.busy = 1'b1;
            model_cycle(s, "seq_freeze");
        end
        model_cycle(mis104, "seq_release");
        model_cycle(idle, "seq_after0");
        model_cycle(idle, "seq_after1");
        checks++;
        if (obs_redirects - red_before != 1) begin
            failures++;
            $display("FAIL seq_once redirects: got %0d expected 1", obs_redirects - red_before);
        end
        checks++;
        if (stall_count !== 32'd5 || flush_count !== 32'd1) begin
            failures++;
            $display("FAIL seq_counts stall/flush: got %0d/%0d expected 5/1",
                     stall_count, flush_count);
        end

        // -------- randomized cycles vs reference model --------
        for (int n = 0; n < 400; n++) begin
            s.rst  = ($urandom_range(99) < 3);
            s.busy = ($urandom_range(99) < 25);
            s.mr   = 1'($urandom_range(1));
            s.rw   = ($urandom_range(3) != 0);
            s.rd   = 5'($urandom_range(3));
            s.rs1  = 5'($urandom_range(3));
            s.rs2  = 5'($urandom_range(3));
            s.br   = ($urandom_range(2) == 0);
            s.pred = 1'($urandom_range(1));
            s.tkn  = 1'($urandom_range(1));
            s.tgt  = $urandom;
            s.pc4  = $urandom;
            model_cycle(s, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
